// File: rtl/sumnb_serial.sv
// sumnb_serial: multi-cycle adder/subtractor, DIGIT bits per clock, LSB digit first.
// Results and flags are registered and held until the next completion.
module sumnb_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] zi,
    output logic             co,
    output logic             ov
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc, w_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT:0]   w_sum;
    logic             w_last, w_cap, w_cmsb;

    assign w_sum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
    assign w_acc  = (r_acc >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_last = r_cnt == CW'(N - 1);
    assign w_cap  = start && (r_state != RUN);
    // carry into a bit position is recovered as a ^ b ^ sum at that position
    assign w_cmsb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];
    assign busy   = r_state == RUN;
    assign done   = r_state == DONE;

    always_comb begin
        w_next = w_cap ? RUN : (r_state == RUN) ? (w_last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_acc <= '0;
            r_cnt <= '0;
            zi    <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else if (w_cap) begin
            r_a   <= xi;
            r_b   <= sub ? ~yi : yi;
            r_c   <= sub;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_c   <= w_sum[DIGIT];
            r_acc <= w_acc;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                zi <= w_acc;
                co <= w_sum[DIGIT];
                ov <= w_cmsb ^ w_sum[DIGIT];
            end
        end
    end
endmodule

// File: tb/tb_sumnb_serial.sv
// tb_sumnb_serial: scoreboard bench over three configurations (4/1, 8/2, 8/8).
module tb_sumnb_serial;
    localparam int WS [3] = '{4, 8, 8};
    localparam int NB [3] = '{4, 4, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [3];
    logic       sub [3];
    logic [7:0] xi [3];
    logic [7:0] yi [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic [9:0] res [3];
    logic [9:0] q [3][$];
    int         bc [3];
    int         n_chk = 0;
    int         n_pass = 0;

    logic [3:0] z4;
    logic [7:0] z8, z88;
    logic       b4, b8, b88, d4, d8, d88, c4, c8, c88, o4, o8, o88;

    sumnb_serial #(.WIDTH(4), .DIGIT(1)) u4 (.clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub[0]),
        .xi(xi[0][3:0]), .yi(yi[0][3:0]), .busy(b4), .done(d4), .zi(z4), .co(c4), .ov(o4));
    sumnb_serial #(.WIDTH(8), .DIGIT(2)) u8 (.clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub[1]),
        .xi(xi[1]), .yi(yi[1]), .busy(b8), .done(d8), .zi(z8), .co(c8), .ov(o8));
    sumnb_serial #(.WIDTH(8), .DIGIT(8)) u88 (.clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub[2]),
        .xi(xi[2]), .yi(yi[2]), .busy(b88), .done(d88), .zi(z88), .co(c88), .ov(o88));

    assign busy_o[0] = b4;
    assign busy_o[1] = b8;
    assign busy_o[2] = b88;
    assign done_o[0] = d4;
    assign done_o[1] = d8;
    assign done_o[2] = d88;
    assign res[0] = {o4, c4, 4'b0, z4};
    assign res[1] = {o8, c8, z8};
    assign res[2] = {o88, c88, z88};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // independent reference: {ov, co, zi zero-extended to 8 bits}
    function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y, input logic s);
        int m  = (1 << w) - 1;
        int xa = int'(x) & m;
        int ya = int'(y) & m;
        int z  = s ? ((xa - ya) & m) : ((xa + ya) & m);
        int sx = (xa >> (w - 1)) & 1;
        int sy = (ya >> (w - 1)) & 1;
        int sz = (z >> (w - 1)) & 1;
        logic c = s ? (xa >= ya) : (((xa + ya) >> w) != 0);
        logic o = s ? ((sx != sy) && (sz != sx)) : ((sx == sy) && (sz != sx));
        return {o, c, 8'(z)};
    endfunction

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (busy_o[u] && done_o[u]) chk($sformatf("u%0d_busy_and_done", u), 1, 0);
            if (done_o[u]) begin
                if (q[u].size() == 0) chk($sformatf("u%0d_unexpected_done", u), 1, 0);
                else begin
                    logic [9:0] e;
                    e = q[u].pop_front();
                    chk($sformatf("u%0d_zi", u), int'(res[u][7:0]), int'(e[7:0]));
                    chk($sformatf("u%0d_co", u), int'(res[u][8]), int'(e[8]));
                    chk($sformatf("u%0d_ov", u), int'(res[u][9]), int'(e[9]));
                    chk($sformatf("u%0d_busy_cycles", u), bc[u], NB[u]);
                end
                bc[u] = 0;
            end else bc[u] = busy_o[u] ? bc[u] + 1 : 0;
        end
    end

    task automatic drive(input int u, input logic [7:0] x, input logic [7:0] y, input logic s);
        @(negedge clk);
        start[u] = 1'b1;
        xi[u] = x;
        yi[u] = y;
        sub[u] = s;
        q[u].push_back(model(WS[u], x, y, s));
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // operands are scrambled every cycle while waiting: the captured values must stick
    task automatic wait_empty(input int u);
        for (int i = 0; i < 40 && q[u].size() != 0; i++) begin
            @(negedge clk);
            #1;
            xi[u] = 8'($urandom);
            yi[u] = 8'($urandom);
            sub[u] = 1'($urandom);
        end
        if (q[u].size() != 0) begin
            chk($sformatf("u%0d_timeout", u), q[u].size(), 0);
            q[u].delete();
        end
    endtask

    task automatic run_op(input int u, input logic [7:0] x, input logic [7:0] y, input logic s);
        drive(u, x, y, s);
        wait_empty(u);
    endtask

    task automatic wait_done(input int u, output time t);
        int i;
        for (i = 0; i < 40 && !done_o[u]; i++) begin
            @(negedge clk);
            #1;
        end
        if (!done_o[u]) chk($sformatf("u%0d_done_timeout", u), 0, 1);
        t = $time;
    endtask

    task automatic check_zero(input string tag);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("%s_u%0d_res", tag, u), int'(res[u]), 0);
            chk($sformatf("%s_u%0d_busy", tag, u), int'(busy_o[u]), 0);
            chk($sformatf("%s_u%0d_done", tag, u), int'(done_o[u]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        time t1, t2;
        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b0;
            sub[u] = 1'b0;
            xi[u] = '0;
            yi[u] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(0, 8'(x), 8'(y), 1'b0);
        run_op(0, 8'd3, 8'd5, 1'b1);
        run_op(0, 8'd5, 8'd3, 1'b1);
        run_op(0, 8'd8, 8'd1, 1'b1);
        run_op(1, 8'h7F, 8'h01, 1'b0);
        run_op(1, 8'hFF, 8'h01, 1'b0);
        run_op(1, 8'h80, 8'h01, 1'b1);
        run_op(2, 8'd200, 8'd100, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom));
            run_op(2, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        // start pulsed mid-RUN must be ignored
        drive(0, 8'd9, 8'd4, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        xi[0] = 8'd1;
        yi[0] = 8'd1;
        sub[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_empty(0);
        repeat (8) @(negedge clk);
        // start held high through DONE: back-to-back captures
        @(negedge clk);
        start[0] = 1'b1;
        xi[0] = 8'd3;
        yi[0] = 8'd9;
        sub[0] = 1'b0;
        q[0].push_back(model(4, 8'd3, 8'd9, 1'b0));
        @(negedge clk);
        xi[0] = 8'd12;
        yi[0] = 8'd2;
        sub[0] = 1'b1;
        q[0].push_back(model(4, 8'd12, 8'd2, 1'b1));
        wait_done(0, t1);
        @(negedge clk);
        #1;
        chk("b2b_busy_after_done", int'(busy_o[0]), 1);
        start[0] = 1'b0;
        wait_done(0, t2);
        chk("b2b_spacing", int'((t2 - t1) / 10), 5);
        wait_empty(0);
        // asynchronous reset during RUN cycle 2 of 6+7
        @(negedge clk);
        start[0] = 1'b1;
        xi[0] = 8'd6;
        yi[0] = 8'd7;
        sub[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_op(0, 8'd6, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
